// File: rtl/if_id_queue.sv
// IF/ID first-word-fall-through queue of DEPTH (pc, instr) pairs; flush empties it in one cycle.
// Push-to-head latency 1 cycle; in_ready = not full (independent of out_ready); empty head reads as zero (nop).
module if_id_queue #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [CNT_W-1:0]       count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             push;
  logic             pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign head      = mem[rp];
  assign pc_out    = out_valid ? head.pc    : '0;
  assign instr_out = out_valid ? head.instr : '0;

  // Storage needs no reset: stale entries are never visible once count is cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= '{pc: pc_in, instr: instr_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed stimulus, reference queue model, negedge monitor.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t exp_q[$];
  int   pass_cnt = 0;
  int   total    = 0;
  bit   mon_en   = 1'b0;

  if_id_queue #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in), .instr_in(instr_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .instr_out(instr_out),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: acceptance decided from the model's own occupancy, never from DUT outputs.
  always @(posedge clk) begin
    bit do_push, do_pop;
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      do_push = in_valid && (exp_q.size() != 4);
      do_pop  = out_ready && (exp_q.size() != 0);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back('{pc: pc_in, instr: instr_in});
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_count", 32'(count), 32'(exp_q.size()));
      chk("mon_in_ready", 32'(in_ready), 32'(exp_q.size() != 4));
      chk("mon_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("mon_pc", pc_out, exp_q[0].pc);
        chk("mon_instr", instr_out, exp_q[0].instr);
      end else begin
        chk("mon_pc_zero", pc_out, 32'h0);
        chk("mon_instr_zero", instr_out, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
    in_valid  = v;
    pc_in     = pc;
    instr_in  = ins;
    out_ready = rdy;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b1, 32'h100, 32'h1, 1'b0);
    step();
    step();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr_out", instr_out, 32'h0);
    mon_en = 1'b1;

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'h20080001 + 32'(i), 1'b0);
      step();
    end
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h10, 32'h20080005, 1'b0);
    step();
    chk("fill_5th_held", 32'(count), 32'd4);
    chk("fill_head_pc", pc_out, 32'h0);

    // Drain in order.
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", pc_out, 32'(4 * i));
      chk("drain_instr", instr_out, 32'h20080001 + 32'(i));
      step();
    end
    chk("drain_empty_valid", 32'(out_valid), 32'd0);
    chk("drain_empty_instr", instr_out, 32'h0);

    // Streaming: count stays 1, PCs follow one cycle behind.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 32'h24000000 + 32'(i), 1'b1);
      step();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_pc", pc_out, 32'h1000 + 32'(4 * i));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("stream_drained", 32'(count), 32'd0);

    // Full with pop: push refused this cycle, accepted the next.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h2000 + 32'(4 * i), 32'h2000 + 32'(i), 1'b0);
      step();
    end
    drive(1'b1, 32'h2010, 32'h2004, 1'b1);
    step();
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_in_ready", 32'(in_ready), 32'd1);
    chk("fullpop_head", pc_out, 32'h2004);
    drive(1'b1, 32'h2010, 32'h2004, 1'b0);
    step();
    chk("fullpop_refill", 32'(count), 32'd4);

    // Flush with a competing push and pop.
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("preflush_count", 32'(count), 32'd3);
    drive(1'b1, 32'hDEAD0000, 32'hDEADBEEF, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    drive(1'b1, 32'h3000, 32'h3, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    chk("postflush_pc", pc_out, 32'h3000);
    step();
    chk("postflush_empty", 32'(out_valid), 32'd0);

    // Reset mid-operation with a push offered.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h4000 + 32'(4 * i), 32'h40 + 32'(i), 1'b0);
      step();
    end
    chk("prerst_count", 32'(count), 32'd2);
    drive(1'b1, 32'h4008, 32'h42, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_pc", pc_out, 32'h0);
    chk("midrst_instr", instr_out, 32'h0);
    drive(1'b1, 32'h5000, 32'h5, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("postrst_count", 32'(count), 32'd1);
    chk("postrst_pc", pc_out, 32'h5000);
    chk("postrst_instr", instr_out, 32'h5);
    out_ready = 1'b1;
    step();
    chk("postrst_empty", 32'(count), 32'd0);
    step();

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
